// File: rtl/ws281x_branch_router.sv
// WS281X branch router: recovers bits and nodes from a WS281X serial stream and
// demultiplexes the stream onto NUM_BR branch outputs, advancing to the next
// branch on an escape node (MODE 0) or after a fixed node count (MODE 1).
// A long idle gap is recognised as a latch and emits a Sync pulse.
module ws281x_branch_router #(
    parameter int          NUM_BR       = 8,
    parameter int          T_SAMPLE     = 30,
    parameter int          T_BRSEL      = 50,
    parameter int          T_LATCH      = 2500,
    parameter int          SYNC_W       = 5,
    parameter int          MODE         = 0,
    parameter logic [23:0] ESC_CODE     = 24'h010203,
    parameter int          NODES_PER_BR = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Din,
    output logic [NUM_BR-1:0]         BranchOut,
    output logic [23:0]               Node,
    output logic                      Valid,
    output logic                      Sync,
    output logic [$clog2(NUM_BR)-1:0] BranchSel,
    output logic                      Overflow
);

    localparam int SEL_W = $clog2(NUM_BR);
    localparam int T_MAX = T_LATCH + SYNC_W;
    localparam int TMR_W = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_SYNC} state_t;

    state_t             state_q;
    logic               meta_q, dins_q, dprev_q;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               sync_q;
    logic [23:0]        shift_q;
    logic [4:0]         bitcnt_q;
    logic               done_q;
    logic [23:0]        node_q;
    logic               valid_q;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               ovf_q, ovf_d;
    logic               pend_q, pend_d;
    logic [11:0]        nodecnt_q, nodecnt_d;
    logic [SEL_W-1:0]   route_q, route_d;
    logic               route_en_q, route_en_d;
    logic [NUM_BR-1:0]  br_q, br_d;

    logic rise, latch_hit, sync_end, sample_hit, brsel_hit;

    // A rising edge outranks every timer compare, so each compare is gated by !rise.
    assign rise       = dins_q & ~dprev_q;
    assign latch_hit  = (state_q == ST_RX)   && !rise && (timer_q == TMR_W'(T_LATCH - 1));
    assign sync_end   = (state_q == ST_SYNC) && !rise && (timer_q == TMR_W'(T_MAX - 1));
    assign sample_hit = !rise && (timer_q == TMR_W'(T_SAMPLE));
    assign brsel_hit  = rise || (timer_q == TMR_W'(T_BRSEL));

    // Bit timer: restart on each rising edge, otherwise count up and hold at T_MAX.
    always_comb begin
        timer_d = timer_q;
        if (rise)
            timer_d = '0;
        else if (timer_q != TMR_W'(T_MAX))
            timer_d = timer_q + 1'b1;
    end

    // Input synchronizer, edge-detect flop and bit timer.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            meta_q  <= 1'b0;
            dins_q  <= 1'b0;
            dprev_q <= 1'b0;
            timer_q <= TMR_W'(T_MAX);
        end else begin
            meta_q  <= Din;
            dins_q  <= meta_q;
            dprev_q <= dins_q;
            timer_q <= timer_d;
        end
    end

    // Latch FSM; Sync is registered and high exactly while in SYNC.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            sync_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) state_q <= ST_RX;
                end
                ST_RX: begin
                    if (latch_hit) begin
                        state_q <= ST_SYNC;
                        sync_q  <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (rise) begin
                        state_q <= ST_RX;
                        sync_q  <= 1'b0;
                    end else if (sync_end) begin
                        state_q <= ST_IDLE;
                        sync_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sync_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bit assembly: sample MSB-first, publish the node one clock after the 24th bit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            done_q   <= 1'b0;
            node_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= done_q;
            if (done_q)
                node_q <= shift_q;
            if (latch_hit) begin
                shift_q  <= '0;
                bitcnt_q <= '0;
            end else if (sample_hit) begin
                shift_q <= {shift_q[22:0], dins_q};
                if (bitcnt_q == 5'd23) begin
                    bitcnt_q <= '0;
                    done_q   <= 1'b1;
                end else begin
                    bitcnt_q <= bitcnt_q + 1'b1;
                end
            end
        end
    end

    // Branch selection: apply pending advance (before route capture on an edge),
    // raise new advance requests from completed nodes, and gate Din to the route.
    always_comb begin
        sel_d      = sel_q;
        ovf_d      = ovf_q;
        pend_d     = pend_q;
        nodecnt_d  = nodecnt_q;
        route_d    = route_q;
        route_en_d = route_en_q;
        br_d       = '0;

        if (pend_q && brsel_hit) begin
            pend_d = 1'b0;
            if (sel_q == SEL_W'(NUM_BR - 1))
                ovf_d = 1'b1;
            else
                sel_d = sel_q + 1'b1;
        end

        if (done_q) begin
            if (MODE == 0) begin
                if (shift_q == ESC_CODE)
                    pend_d = 1'b1;
            end else begin
                if (nodecnt_q == 12'(NODES_PER_BR - 1)) begin
                    pend_d    = 1'b1;
                    nodecnt_d = '0;
                end else begin
                    nodecnt_d = nodecnt_q + 1'b1;
                end
            end
        end

        if (latch_hit) begin
            sel_d     = '0;
            ovf_d     = 1'b0;
            pend_d    = 1'b0;
            nodecnt_d = '0;
        end

        if (rise) begin
            route_d    = sel_d;
            route_en_d = ~ovf_d;
        end

        for (int i = 0; i < NUM_BR; i++)
            br_d[i] = dins_q & route_en_d & (route_d == SEL_W'(i));
    end

    // Branch selection and routed output registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sel_q      <= '0;
            ovf_q      <= 1'b0;
            pend_q     <= 1'b0;
            nodecnt_q  <= '0;
            route_q    <= '0;
            route_en_q <= 1'b0;
            br_q       <= '0;
        end else begin
            sel_q      <= sel_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            nodecnt_q  <= nodecnt_d;
            route_q    <= route_d;
            route_en_q <= route_en_d;
            br_q       <= br_d;
        end
    end

    assign BranchOut = br_q;
    assign Node      = node_q;
    assign Valid     = valid_q;
    assign Sync      = sync_q;
    assign BranchSel = sel_q;
    assign Overflow  = ovf_q;

endmodule
